cpu_run_controller: RTL and testbench

- Parametrised run/supervision block for the MIPS core. Generalises "toggle clk and let the core run" into a controlled run.
- Holds the core in reset for a programmable number of cycles, then releases it and counts execution cycles.
- Detects program completion (PC self-loop halt idiom, e.g. `beq $0,$0,-1`) or a watchdog timeout, and reports done/status.
- Sits between the top-level clock/reset and the CPU's reset input. It is usable in synthesis and on the simulation harness.

---
 rtl/run_ctrl_pkg.sv | 28 ++
 rtl/cpu_run_controller_pc_history_buf.sv | 40 ++++
 rtl/cpu_run_controller.sv | 146 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// The optional PC history buffer is enabled by RUN_CTRL_PC_HISTORY_EN.
package run_ctrl_pkg;

  typedef logic [2:0] run_state_t;

  localparam run_state_t ST_IDLE       = 3'd0;
  localparam run_state_t ST_RESET_HOLD = 3'd1;
  localparam run_state_t ST_RUN        = 3'd2;
  localparam run_state_t ST_HALTED     = 3'd3;
  localparam run_state_t ST_TIMEOUT    = 3'd4;

  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int DEF_HALT_REPEAT  = 3;
  localparam int DEF_MAX_CYCLES   = 1000;
  localparam int DEF_HIST_DEPTH   = 8;

  // Ceiling log2, never below 1 so it can size a counter or index directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cpu_run_controller_pc_history_buf.sv
// Ring buffer of recently fetched distinct PCs; read index 0 is the newest entry.
// Only instantiated when RUN_CTRL_PC_HISTORY_EN is defined.
module pc_history_buf
  import run_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_HIST_DEPTH,
  parameter int WIDTH = DEF_PC_WIDTH,
  parameter int IDX_W = clog2(DEF_HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  // Entries are cleared (not just the pointer) so unwritten slots read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cpu_run_controller.sv
// Run/supervision block: holds the core in reset, runs it, detects PC self-loop halt or watchdog.
// Define RUN_CTRL_PC_HISTORY_EN to add the hist_idx/hist_pc PC history read port.
module cpu_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int HALT_REPEAT  = DEF_HALT_REPEAT,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int HIST_DEPTH   = DEF_HIST_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_valid,
  output logic                 cpu_rst_n,
  output logic                 running,
  output logic                 done,
  output logic                 timed_out,
  output logic [PC_WIDTH-1:0]  halt_pc,
  output logic [CNT_WIDTH-1:0] cycle_count
`ifdef RUN_CTRL_PC_HISTORY_EN
  ,
  input  logic [clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [PC_WIDTH-1:0]          hist_pc
`endif
);

  localparam int HOLD_W = clog2(RESET_CYCLES + 1);
  localparam int SAME_W = clog2(HALT_REPEAT + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [SAME_W-1:0]    SAME_HALT = SAME_W'(HALT_REPEAT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_t          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [SAME_W-1:0]   same_cnt;
  logic [PC_WIDTH-1:0] last_pc;

  logic                pc_new;
  logic [SAME_W-1:0]   same_inc;
  logic                halt_hit;
  logic                wdog_hit;
  logic                run_entry;

  // same_cnt==0 marks the first valid sample of a run, which always counts as a new PC.
  assign pc_new    = (same_cnt == '0) || (pc != last_pc);
  assign same_inc  = pc_new ? SAME_W'(1) : same_cnt + 1'b1;
  assign halt_hit  = (state == ST_RUN) && pc_valid && (same_inc == SAME_HALT);
  assign wdog_hit  = (state == ST_RUN) && !halt_hit && (cycle_count == CNT_LAST);
  assign run_entry = (state == ST_RESET_HOLD) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      same_cnt    <= '0;
      last_pc     <= '0;
      cpu_rst_n   <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_rst_n <= 1'b0;
          running   <= 1'b0;
          if (start) begin
            state    <= ST_RESET_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_RESET_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (run_entry) begin
            state       <= ST_RUN;
            cpu_rst_n   <= 1'b1;
            running     <= 1'b1;
            cycle_count <= '0;
            same_cnt    <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            halt_pc     <= '0;
          end
        end
        ST_RUN: begin
          if (pc_valid) begin
            same_cnt <= same_inc;
            if (pc_new) last_pc <= pc;
          end
          // The halting cycle is counted; on watchdog expiry the count stays at MAX_CYCLES-1.
          if (halt_hit) begin
            state       <= ST_HALTED;
            running     <= 1'b0;
            done        <= 1'b1;
            halt_pc     <= pc;
            cycle_count <= cycle_count + 1'b1;
          end else if (wdog_hit) begin
            state     <= ST_TIMEOUT;
            running   <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          if (start) begin
            state     <= ST_RESET_HOLD;
            hold_cnt  <= '0;
            cpu_rst_n <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cpu_rst_n <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_CTRL_PC_HISTORY_EN
  logic hist_we;
  assign hist_we = (state == ST_RUN) && pc_valid && pc_new;

  pc_history_buf #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (PC_WIDTH),
    .IDX_W (clog2(HIST_DEPTH))
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (run_entry),
    .wr_en   (hist_we),
    .wr_data (pc),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed, table-driven bench for cpu_run_controller (RESET_CYCLES=4, HALT_REPEAT=3, MAX_CYCLES=50).
// History checks are compiled in only when RUN_CTRL_PC_HISTORY_EN is defined.
module tb_cpu_run_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        pc_valid;
  logic        cpu_rst_n;
  logic        running;
  logic        done;
  logic        timed_out;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;
`ifdef RUN_CTRL_PC_HISTORY_EN
  logic [2:0]  hist_idx;
  logic [31:0] hist_pc;
`endif

  int errors = 0;
  int checks = 0;

  cpu_run_controller #(
    .PC_WIDTH     (32),
    .CNT_WIDTH    (32),
    .RESET_CYCLES (4),
    .HALT_REPEAT  (3),
    .MAX_CYCLES   (50),
    .HIST_DEPTH   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .cpu_rst_n   (cpu_rst_n),
    .running     (running),
    .done        (done),
    .timed_out   (timed_out),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count)
`ifdef RUN_CTRL_PC_HISTORY_EN
    ,
    .hist_idx    (hist_idx),
    .hist_pc     (hist_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        pc_valid;
    logic [31:0] pc;
    logic        e_cpu_rst_n;
    logic        e_running;
    logic        e_done;
    logic        e_timed_out;
    logic [31:0] e_cycle_count;
    logic [31:0] e_halt_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic s, logic pv, logic [31:0] p, logic r, logic run,
                             logic d, logic t, logic [31:0] c, logic [31:0] h);
    vec_t x;
    x.start = s; x.pc_valid = pv; x.pc = p;
    x.e_cpu_rst_n = r; x.e_running = run; x.e_done = d; x.e_timed_out = t;
    x.e_cycle_count = c; x.e_halt_pc = h;
    return x;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic r, logic run, logic d, logic t,
                           logic [31:0] c, logic [31:0] h);
    check({tag, ".cpu_rst_n"}, cpu_rst_n, r);
    check({tag, ".running"}, running, run);
    check({tag, ".done"}, done, d);
    check({tag, ".timed_out"}, timed_out, t);
    check({tag, ".cycle_count"}, cycle_count, c);
    check({tag, ".halt_pc"}, halt_pc, h);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; pc = '0; pc_valid = 1'b0;
`ifdef RUN_CTRL_PC_HISTORY_EN
    hist_idx = '0;
`endif

    //        start pv  pc     rst run done to  cnt  halt_pc
    vecs.push_back(v(1, 0, 32'h00, 0, 0, 0, 0, 0, 32'h0));  // start -> hold
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0, 32'h00, 1, 1, 0, 0, 0, 32'h0));  // run entry
    vecs.push_back(v(0, 1, 32'h00, 1, 1, 0, 0, 1, 32'h0));
    vecs.push_back(v(0, 1, 32'h04, 1, 1, 0, 0, 2, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 3, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 4, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 0, 1, 0, 5, 32'h8));  // halt
    vecs.push_back(v(0, 1, 32'h08, 1, 0, 1, 0, 5, 32'h8));  // frozen
    vecs.push_back(v(1, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));  // restart from halted
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 1, 1, 0, 0, 0, 32'h0));  // run entry clears
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 1, 32'h0));  // gap tolerance
    vecs.push_back(v(0, 0, 32'h00, 1, 1, 0, 0, 2, 32'h0));
    vecs.push_back(v(0, 0, 32'h00, 1, 1, 0, 0, 3, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 4, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 0, 1, 0, 5, 32'h8));  // halt across gap
    vecs.push_back(v(1, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 0, 0, 1, 0, 5, 32'h8));
    vecs.push_back(v(0, 0, 32'h00, 1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 1, 32'h0));  // interrupted repeat
    vecs.push_back(v(0, 1, 32'h0C, 1, 1, 0, 0, 2, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 3, 32'h0));
    vecs.push_back(v(0, 1, 32'h08, 1, 1, 0, 0, 4, 32'h0));
    vecs.push_back(v(1, 1, 32'h10, 1, 1, 0, 0, 5, 32'h0));  // start in RUN ignored

    // Reset state
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_all("idle", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; pc_valid = vecs[i].pc_valid; pc = vecs[i].pc;
      tick();
      $display("vec %0d: start=%0b valid=%0b pc=%0h -> cpu_rst_n=%0b running=%0b done=%0b to=%0b cnt=%0d halt_pc=%0h",
               i, start, pc_valid, pc, cpu_rst_n, running, done, timed_out, cycle_count, halt_pc);
      check_all($sformatf("vec%0d", i), vecs[i].e_cpu_rst_n, vecs[i].e_running, vecs[i].e_done,
                vecs[i].e_timed_out, vecs[i].e_cycle_count, vecs[i].e_halt_pc);
    end
    start = 1'b0; pc_valid = 1'b0;

    // Asynchronous reset between clock edges while in RUN
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: cpu_rst_n=%0b running=%0b cnt=%0d", cpu_rst_n, running, cycle_count);
    check("async.cpu_rst_n", cpu_rst_n, 0);
    check("async.running", running, 0);
    check("async.cycle_count", cycle_count, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_after_async%0d.cpu_rst_n", i), cpu_rst_n, 0);
      check($sformatf("idle_after_async%0d.running", i), running, 0);
    end

    // Watchdog: incrementing PC never halts
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    tick();
    check_all("wdog_entry", 1, 1, 0, 0, 0, 0);
    n = 0;
    while (!done && n < 200) begin
      pc_valid = 1'b1; pc = 32'h1000 + 32'(4 * n);
      tick();
      n++;
      if (n == 49) check_all("wdog_pre", 1, 1, 0, 0, 49, 0);
    end
    $display("timeout after %0d run cycles: done=%0b to=%0b cnt=%0d", n, done, timed_out, cycle_count);
    check("wdog.run_cycles", n, 50);
    check_all("wdog", 1, 0, 1, 1, 49, 0);

    // Restart from TIMEOUT, then halt landing on the watchdog cycle
    pc_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_all("restart_to_hold", 0, 0, 1, 1, 49, 0);
    repeat (3) tick();
    tick();
    check_all("restart_to_run", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      pc_valid = 1'b1; pc = (i >= 47) ? 32'h200 : 32'(4 * i);
      tick();
      if (i == 48) check_all("collide_pre", 1, 1, 0, 0, 49, 0);
    end
    $display("collision: done=%0b to=%0b cnt=%0d halt_pc=%0h", done, timed_out, cycle_count, halt_pc);
    check_all("collide", 1, 0, 1, 0, 50, 32'h200);

`ifdef RUN_CTRL_PC_HISTORY_EN
    pc_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    tick();
    hist_idx = 3'd0; #1;
    check("hist.cleared", hist_pc, 0);
    for (int i = 0; i < 10; i++) begin
      pc_valid = 1'b1; pc = 32'(4 * i);
      tick();
    end
    pc_valid = 1'b0;
    hist_idx = 3'd0; #1;
    $display("hist[0]=%0h", hist_pc);
    check("hist.idx0", hist_pc, 32'h24);
    hist_idx = 3'd1; #1;
    $display("hist[1]=%0h", hist_pc);
    check("hist.idx1", hist_pc, 32'h20);
    hist_idx = 3'd7; #1;
    $display("hist[7]=%0h", hist_pc);
    check("hist.idx7", hist_pc, 32'h08);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
